// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl: builds the ciphertext, sequences the decrypt core and scans plaintext[31:0] onto 8 hex digits.
// Optional RUN-state watchdog is compiled in with `define DEC_TIMEOUT_EN.

module decrypt_ctrl #(
    parameter logic [111:0] CT_HI     = 112'h646e277420646563727970742074,
    parameter int unsigned  SCAN_BITS = 21,
    parameter int unsigned  TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  sw,
    output logic         core_rst,
    output logic [127:0] core_c,
    input  logic [127:0] core_p,
    input  logic         core_tag_ok,
    input  logic         core_done,
    output logic         busy,
    output logic         valid,
    output logic         fail,
    output logic [7:0]   an,
    output logic [3:0]   nibble
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic                 core_rst_q;
    logic                 busy_q;
    logic                 valid_q;
    logic                 fail_q;
    logic [15:0]          sw_q;
    logic [31:0]          p_q;
    logic [SCAN_BITS-1:0] scan_q;
    logic [7:0]           an_q;
    logic [3:0]           nibble_q;
    logic [3:0]           nibble_d;
    logic [2:0]           digit;
    logic [4:0]           bit_idx;
    logic                 to_hit;
    logic                 unused_p_hi;

    // Only plaintext[31:0] is ever displayed.
    assign unused_p_hi = ^core_p[127:32];

`ifdef DEC_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] to_q;
    assign to_hit = (to_q == TO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = TIMEOUT[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            fail_q     <= 1'b0;
            sw_q       <= '0;
            p_q        <= '0;
`ifdef DEC_TIMEOUT_EN
            to_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Results are cleared on entry so they already read 0 during LOAD.
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        fail_q  <= 1'b0;
                        p_q     <= '0;
                    end
                end
                S_LOAD: begin
                    sw_q       <= sw;
                    core_rst_q <= 1'b0;
                    state_q    <= S_RUN;
`ifdef DEC_TIMEOUT_EN
                    to_q       <= '0;
`endif
                end
                S_RUN: begin
                    if (core_done) begin
                        state_q    <= S_DONE;
                        core_rst_q <= 1'b1;
                        busy_q     <= 1'b0;
                        if (core_tag_ok) begin
                            valid_q <= 1'b1;
                            p_q     <= core_p[31:0];
                        end else begin
                            fail_q  <= 1'b1;
                            p_q     <= '0;
                        end
                    end else if (to_hit) begin
                        state_q    <= S_DONE;
                        core_rst_q <= 1'b1;
                        busy_q     <= 1'b0;
                        fail_q     <= 1'b1;
                        p_q        <= '0;
                    end
`ifdef DEC_TIMEOUT_EN
                    else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign digit   = scan_q[SCAN_BITS-1 -: 3];
    assign bit_idx = {digit, 2'b00};

    always_comb begin
        nibble_d = 4'h0;
        if (valid_q) begin
            nibble_d = p_q[bit_idx +: 4];
        end else if (fail_q) begin
            nibble_d = 4'hE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q   <= '0;
            an_q     <= '1;
            nibble_q <= '0;
        end else begin
            scan_q   <= scan_q + 1'b1;
            an_q     <= ~(8'b1 << digit);
            nibble_q <= nibble_d;
        end
    end

    assign core_rst = core_rst_q;
    assign core_c   = {CT_HI, sw_q};
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign fail     = fail_q;
    assign an       = an_q;
    assign nibble   = nibble_q;

endmodule
